// File: rtl/wb_scoreboard_if.sv
// Writeback/scoreboard bus: decode issue port, ALU and load result offers,
// and the registered register-file write port.
interface wb_scoreboard_if #(
   parameter int unsigned mode = 32,
   parameter int unsigned aw   = 5
);
   logic            issue_valid;
   logic            issue_wr;
   logic [aw-1:0]   issue_rd;
   logic [aw-1:0]   issue_rs1;
   logic [aw-1:0]   issue_rs2;
   logic            hazard;

   logic            alu_valid;
   logic [aw-1:0]   alu_rd;
   logic [mode-1:0] alu_data;
   logic            alu_ready;

   logic            ld_valid;
   logic [aw-1:0]   ld_rd;
   logic [mode-1:0] ld_data;
   logic            ld_ready;

   logic            write;
   logic [aw-1:0]   sel_write_reg;
   logic [mode-1:0] data_in;
   logic            err;

   modport slave (
      input  issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output hazard, alu_ready, ld_ready,
      output write, sel_write_reg, data_in, err
   );

   modport master (
      output issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  hazard, alu_ready, ld_ready,
      input  write, sel_write_reg, data_in, err
   );
endinterface

// File: rtl/wb_scoreboard.sv
// Writeback arbiter (ALU vs load, round-robin) feeding the register file's
// single registered write port, plus per-register pending scoreboard that
// raises a decode stall on RAW/WAW hazards.
module wb_scoreboard #(
   parameter int unsigned mode       = 32,
   parameter int unsigned reg_number = 32
) (
   input logic            clk,
   input logic            reset_n,
   wb_scoreboard_if.slave bus
);
   localparam int unsigned aw = $clog2(reg_number);

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LD  = 1'b1
   } grant_e;

   logic [reg_number-1:0] pending_q, pending_d;
   grant_e                last_grant_q, last_grant_d;
   logic                  write_q, write_d;
   logic [aw-1:0]         sel_write_reg_q, sel_write_reg_d;
   logic [mode-1:0]       data_in_q, data_in_d;
   logic                  err_q, err_d;

   logic                  hazard_c;
   logic                  issue_c;
   logic                  alu_gnt_c;
   logic                  ld_gnt_c;
   logic [aw-1:0]         acc_rd_c;
   logic [mode-1:0]       acc_data_c;

   // Stall decode while any operand or the destination awaits writeback
   always_comb begin
      hazard_c = 1'b0;
      if (bus.issue_valid) begin
         hazard_c = pending_q[bus.issue_rs1] | pending_q[bus.issue_rs2] |
                    (bus.issue_wr & pending_q[bus.issue_rd]);
      end
      issue_c = bus.issue_valid & ~hazard_c;
   end

   // Round-robin grant: on a tie the source not granted last time wins
   always_comb begin
      alu_gnt_c = 1'b0;
      ld_gnt_c  = 1'b0;
      if (bus.alu_valid && bus.ld_valid) begin
         if (last_grant_q == GRANT_ALU) ld_gnt_c  = 1'b1;
         else                           alu_gnt_c = 1'b1;
      end else begin
         alu_gnt_c = bus.alu_valid;
         ld_gnt_c  = bus.ld_valid;
      end
      acc_rd_c   = ld_gnt_c ? bus.ld_rd   : bus.alu_rd;
      acc_data_c = ld_gnt_c ? bus.ld_data : bus.alu_data;
   end

   // Next state: pending clear on write, set on issue (set applied last so
   // it wins), accepted result loads the write port, sticky error
   always_comb begin
      pending_d       = pending_q;
      last_grant_d    = last_grant_q;
      write_d         = 1'b0;
      sel_write_reg_d = sel_write_reg_q;
      data_in_d       = data_in_q;
      err_d           = err_q;

      if (write_q) pending_d[sel_write_reg_q] = 1'b0;
      if (issue_c && bus.issue_wr && (bus.issue_rd != '0)) pending_d[bus.issue_rd] = 1'b1;

      if (alu_gnt_c || ld_gnt_c) begin
         last_grant_d = ld_gnt_c ? GRANT_LD : GRANT_ALU;
         if (acc_rd_c != '0) begin
            write_d         = 1'b1;
            sel_write_reg_d = acc_rd_c;
            data_in_d       = acc_data_c;
            if (!pending_q[acc_rd_c]) err_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q       <= '0;
         last_grant_q    <= GRANT_ALU;
         write_q         <= 1'b0;
         sel_write_reg_q <= '0;
         data_in_q       <= '0;
         err_q           <= 1'b0;
      end else begin
         pending_q       <= pending_d;
         last_grant_q    <= last_grant_d;
         write_q         <= write_d;
         sel_write_reg_q <= sel_write_reg_d;
         data_in_q       <= data_in_d;
         err_q           <= err_d;
      end
   end

   assign bus.hazard        = hazard_c;
   assign bus.alu_ready     = alu_gnt_c;
   assign bus.ld_ready      = ld_gnt_c;
   assign bus.write         = write_q;
   assign bus.sel_write_reg = sel_write_reg_q;
   assign bus.data_in       = data_in_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a model.
module tb_wb_scoreboard;
   localparam int unsigned MODE = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic reset_n;

   wb_scoreboard_if #(.mode(MODE), .aw(AW)) bus ();

   wb_scoreboard #(.mode(MODE), .reg_number(NREG)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [AW-1:0]   rd;
      logic [MODE-1:0] data;
   } offer_t;

   offer_t alu_offers[$];
   offer_t ld_offers[$];
   bit     alu_fire;
   bit     ld_fire;

   // Model: set of registers awaiting writeback, who won last, and what the
   // write port must show this cycle.
   bit              m_pend[NREG];
   bit              m_last_ld;
   bit              m_write;
   logic [AW-1:0]   m_sel;
   logic [MODE-1:0] m_data;
   bit              m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(NREG); i++) m_pend[i] = 1'b0;
      m_last_ld = 1'b0;
      m_write   = 1'b0;
      m_sel     = '0;
      m_data    = '0;
      m_err     = 1'b0;
   endfunction

   // Per-cycle compare against the model, then advance the model by one edge
   always @(negedge clk) begin : compare
      bit              e_haz, g_alu, g_ld, old_w;
      logic [AW-1:0]   rd, old_sel;
      logic [MODE-1:0] data;
      if (reset_n !== 1'b1) model_reset();
      e_haz = bus.issue_valid && (m_pend[bus.issue_rs1] || m_pend[bus.issue_rs2] ||
                                  (bus.issue_wr && m_pend[bus.issue_rd]));
      g_ld  = bus.ld_valid && (!bus.alu_valid || !m_last_ld);
      g_alu = bus.alu_valid && !g_ld;
      chk("hazard",        bus.hazard,        e_haz);
      chk("alu_ready",     bus.alu_ready,     g_alu);
      chk("ld_ready",      bus.ld_ready,      g_ld);
      chk("write",         bus.write,         m_write);
      chk("sel_write_reg", bus.sel_write_reg, m_sel);
      chk("data_in",       bus.data_in,       m_data);
      chk("err",           bus.err,           m_err);
      alu_fire = 1'b0;
      ld_fire  = 1'b0;
      if (reset_n === 1'b1) begin
         alu_fire = g_alu;
         ld_fire  = g_ld;
         old_w    = m_write;
         old_sel  = m_sel;
         m_write  = 1'b0;
         if (g_alu || g_ld) begin
            rd        = g_ld ? bus.ld_rd   : bus.alu_rd;
            data      = g_ld ? bus.ld_data : bus.alu_data;
            m_last_ld = g_ld;
            if (rd != '0) begin
               if (!m_pend[rd]) m_err = 1'b1;
               m_write = 1'b1;
               m_sel   = rd;
               m_data  = data;
            end
         end
         if (old_w) m_pend[old_sel] = 1'b0;
         if (bus.issue_valid && !e_haz && bus.issue_wr && bus.issue_rd != '0)
            m_pend[bus.issue_rd] = 1'b1;
      end
   end

   task automatic step_sources();
      offer_t o;
      if (alu_fire) bus.alu_valid = 1'b0;
      if (ld_fire)  bus.ld_valid  = 1'b0;
      if (!bus.alu_valid && alu_offers.size() > 0) begin
         o = alu_offers.pop_front();
         bus.alu_valid = 1'b1; bus.alu_rd = o.rd; bus.alu_data = o.data;
      end
      if (!bus.ld_valid && ld_offers.size() > 0) begin
         o = ld_offers.pop_front();
         bus.ld_valid = 1'b1; bus.ld_rd = o.rd; bus.ld_data = o.data;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      step_sources();
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic kill_sources();
      alu_offers.delete();
      ld_offers.delete();
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
   endtask

   task automatic set_issue(input bit v, input bit wr, input int rd, input int rs1, input int rs2);
      bus.issue_valid = v;
      bus.issue_wr    = wr;
      bus.issue_rd    = AW'(rd);
      bus.issue_rs1   = AW'(rs1);
      bus.issue_rs2   = AW'(rs2);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      kill_sources();
      set_issue(0, 0, 0, 0, 0);
      at_neg();
      chk("rst_write", bus.write, 1'b0);
      chk("rst_err",   bus.err,   1'b0);
      cycle();
      reset_n = 1'b1;
   endtask

   function automatic bit offered(input int idx);
      if (bus.alu_valid && bus.alu_rd == AW'(idx)) return 1'b1;
      if (bus.ld_valid  && bus.ld_rd  == AW'(idx)) return 1'b1;
      foreach (alu_offers[i]) if (alu_offers[i].rd == AW'(idx)) return 1'b1;
      foreach (ld_offers[i])  if (ld_offers[i].rd  == AW'(idx)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [AW-1:0] pick_rd();
      int start = int'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 7) == 0) return AW'(start);
      for (int i = 0; i < int'(NREG); i++) begin
         int idx = (start + i) % int'(NREG);
         if (m_pend[idx] && !offered(idx)) return AW'(idx);
      end
      return AW'(start);
   endfunction

   initial begin
      reset_n = 1'b0;
      kill_sources();
      bus.alu_rd = '0; bus.alu_data = '0; bus.ld_rd = '0; bus.ld_data = '0;
      set_issue(0, 0, 0, 0, 0);
      repeat (2) at_neg();
      cycle();
      reset_n = 1'b1;

      // Quiet after reset release
      at_neg();
      chk("t1_write", bus.write, 1'b0);
      chk("t1_hazard", bus.hazard, 1'b0);
      chk("t1_err", bus.err, 1'b0);
      chk("t1_alu_ready", bus.alu_ready, 1'b0);
      chk("t1_ld_ready", bus.ld_ready, 1'b0);

      // RAW on r5 and its release two cycles after acceptance
      cycle();
      set_issue(1, 1, 5, 0, 0);
      cycle();
      set_issue(1, 0, 0, 5, 0);
      at_neg();
      chk("t2_hazard_set", bus.hazard, 1'b1);
      alu_offers.push_back('{rd: AW'(5), data: 32'hDEADBEEF});
      cycle();
      at_neg();
      chk("t2_alu_ready", bus.alu_ready, 1'b1);
      chk("t2_hazard_n", bus.hazard, 1'b1);
      cycle();
      at_neg();
      chk("t2_write", bus.write, 1'b1);
      chk("t2_sel", bus.sel_write_reg, 64'd5);
      chk("t2_data", bus.data_in, 64'hDEADBEEF);
      chk("t2_hazard_n1", bus.hazard, 1'b1);
      cycle();
      at_neg();
      chk("t2_hazard_n2", bus.hazard, 1'b0);
      chk("t2_write_n2", bus.write, 1'b0);

      // Sustained tie alternates LD, ALU, LD, ALU
      cycle();
      do_reset();
      set_issue(1, 1, 1, 0, 0);
      for (int i = 2; i <= 4; i++) begin
         cycle();
         set_issue(1, 1, i, 0, 0);
      end
      ld_offers.push_back('{rd: AW'(1), data: 32'h11111111});
      ld_offers.push_back('{rd: AW'(3), data: 32'h33333333});
      ld_offers.push_back('{rd: AW'(0), data: 32'h00000000});
      alu_offers.push_back('{rd: AW'(2), data: 32'h22222222});
      alu_offers.push_back('{rd: AW'(4), data: 32'h44444444});
      cycle();
      set_issue(0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         at_neg();
         chk("t3_ld_ready", bus.ld_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("t3_alu_ready", bus.alu_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
         if (k > 0) chk("t3_sel", bus.sel_write_reg, 64'(k));
         cycle();
      end
      at_neg();
      chk("t3_last_write", bus.write, 1'b1);
      chk("t3_last_sel", bus.sel_write_reg, 64'd4);
      chk("t3_last_data", bus.data_in, 64'h44444444);
      chk("t3_err", bus.err, 1'b0);

      // r0 is never pending and its results are dropped
      cycle();
      do_reset();
      set_issue(1, 1, 0, 0, 0);
      cycle();
      at_neg();
      chk("t4_hazard_r0", bus.hazard, 1'b0);
      alu_offers.push_back('{rd: AW'(0), data: 32'hCAFEF00D});
      cycle();
      at_neg();
      chk("t4_alu_ready", bus.alu_ready, 1'b1);
      cycle();
      at_neg();
      chk("t4_write", bus.write, 1'b0);
      chk("t4_err", bus.err, 1'b0);

      // Result for a non-pending register sets sticky err but still writes
      set_issue(0, 0, 0, 0, 0);
      ld_offers.push_back('{rd: AW'(7), data: 32'h00000077});
      cycle();
      at_neg();
      chk("t5_ld_ready", bus.ld_ready, 1'b1);
      cycle();
      at_neg();
      chk("t5_write", bus.write, 1'b1);
      chk("t5_sel", bus.sel_write_reg, 64'd7);
      chk("t5_err", bus.err, 1'b1);
      repeat (3) cycle();
      at_neg();
      chk("t5_err_sticky", bus.err, 1'b1);

      // Reset with pending bits and a write in flight
      cycle();
      do_reset();
      set_issue(1, 1, 3, 0, 0);
      cycle();
      set_issue(1, 1, 9, 0, 0);
      cycle();
      set_issue(0, 0, 0, 0, 0);
      alu_offers.push_back('{rd: AW'(3), data: 32'h33330000});
      ld_offers.push_back('{rd: AW'(9), data: 32'h99990000});
      cycle();
      cycle();
      reset_n = 1'b0;
      kill_sources();
      at_neg();
      chk("t6_write", bus.write, 1'b0);
      chk("t6_sel", bus.sel_write_reg, 64'd0);
      chk("t6_data", bus.data_in, 64'd0);
      chk("t6_err", bus.err, 1'b0);
      cycle();
      reset_n = 1'b1;
      set_issue(1, 0, 0, 3, 9);
      at_neg();
      chk("t6_hazard", bus.hazard, 1'b0);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 4000; c++) begin
         cycle();
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) begin
            reset_n = 1'b0;
            kill_sources();
         end
         set_issue($urandom_range(0, 1), $urandom_range(0, 1),
                   int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, NREG - 1)));
         if (reset_n && alu_offers.size() == 0 && $urandom_range(0, 9) < 6)
            alu_offers.push_back('{rd: pick_rd(), data: $urandom()});
         if (reset_n && ld_offers.size() == 0 && $urandom_range(0, 9) < 6)
            ld_offers.push_back('{rd: pick_rd(), data: $urandom()});
      end

      set_issue(0, 0, 0, 0, 0);
      kill_sources();
      repeat (3) cycle();
      at_neg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Writeback arbiter and register scoreboard on the write side of the RV32I register file. It accepts results from the ALU and the load unit over valid/ready handshakes and arbitrates them round-robin onto the register file's single registered write port. It also keeps one pending bit per architectural register, and tells decode to stall while any operand or destination of the instruction being issued still awaits writeback.

## Interface
- mode, default 32: data width.
- reg_number, default 32: number of architectural registers. Register addresses are $clog2(reg_number) bits wide (AW).
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- issue_valid  input  1  decode presents an instruction.
- issue_wr  input  1  the instruction writes rd.
- issue_rd, issue_rs1, issue_rs2  input  AW each  destination and source register addresses.
- hazard  output  1  combinational stall request to decode.
- alu_valid, alu_rd, alu_data  input  1/AW/mode  ALU result offer.
- alu_ready  output  1  ALU result accepted this cycle.
- ld_valid, ld_rd, ld_data  input  1/AW/mode  load result offer.
- ld_ready  output  1  load result accepted this cycle.
- write  output  1  register-file write enable, registered.
- sel_write_reg  output  AW  register-file write address, registered.
- data_in  output  mode  register-file write data, registered.
- err  output  1  sticky flag: a result arrived for a register that was not pending.

## Operation
- Reset is asynchronous and active-low (reset_n); there is one clock (clk).
- State held: pending[reg_number-1:0], last_grant (ALU or LD), and the output registers write, sel_write_reg, data_in, err.
- Hazard check:
  - hazard = issue_valid & (pending[issue_rs1] | pending[issue_rs2] | (issue_wr & pending[issue_rd])).
  - Register 0 is never pending, so it never causes a hazard.
- Issue:
  - An instruction issues when issue_valid & !hazard.
  - If it issues with issue_wr=1 and issue_rd≠0, pending[issue_rd] is set at the next clock edge.
- Arbitration:
  - Only one source offers: it is granted.
  - Both offer: the source not in last_grant is granted.
  - last_grant updates on every grant.
  - alu_ready/ld_ready are combinational and equal to the grant. At most one is high per cycle.
- Source handshake: a source holds valid, rd and data stable until it sees ready. A transfer happens on a cycle with valid & ready.
- Accepted result with rd≠0:
  - At the next edge: write=1, sel_write_reg=rd, data_in=data.
  - If pending[rd]=0 at acceptance, err is set. The write still happens.
- Accepted result with rd=0: consumed, but write=0 next cycle and no pending change.
- No grant in a cycle: write=0 next cycle. sel_write_reg and data_in hold their previous values.
- Pending clear: pending[sel_write_reg] is cleared at the edge on which write=1 is sampled. This is the same edge at which the register file stores the data.
- Set and clear on the same register at the same edge cannot occur: the WAW term in hazard blocks such an issue. If it is forced anyway, set wins.
- err is cleared only by reset.

## Timing
- Reset values:
  - pending all 0; last_grant = ALU, so the first tie grants LD.
  - write=0, sel_write_reg=0, data_in=0, err=0.
  - alu_ready, ld_ready and hazard follow their inputs combinationally, so they are 0 when no valid inputs are present.
- Result accepted in cycle N:
  - write=1 during cycle N+1.
  - The register file is updated and the pending bit cleared at the end of N+1.
  - hazard on that register drops in cycle N+2.
- Throughput: one writeback per cycle. Under a sustained tie the sources alternate LD, ALU, LD, ...
- Reset mid-operation clears all pending bits and any in-flight write immediately. Sources must re-offer after reset.

## Test plan
- Reset is released with no inputs driven -> write=0, hazard=0, err=0, both ready outputs 0.
- Issue rd=5. Next cycle, issue rs1=5 -> hazard=1. ALU offers rd=5, data=0xDEADBEEF, accepted in cycle N -> write=1, sel_write_reg=5, data_in=0xDEADBEEF in N+1; hazard=0 in N+2.
- Both sources valid for 4 consecutive cycles after reset -> grants go LD, ALU, LD, ALU; write asserted in each following cycle with the matching rd/data.
- Issue with rd=0 and issue_wr=1 -> pending unchanged. ALU result for rd=0 -> alu_ready=1, write stays 0, err=0.
- Load result for rd=7 with pending[7]=0 -> err=1 and stays 1; write=1, sel_write_reg=7.
- Set pending on r3 and r9, assert reset_n=0 for one cycle mid-stream -> all outputs return to reset values, and hazard=0 for rs1=3, rs2=9.
